alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL be >=4 and a power of two.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port in_valid  input  1  request carries a valid op/a/b.
REQ-005 Port in_ready  output  1  block can accept a request.
REQ-006 Port op  input  4  operation code (see REQ-012).
REQ-007 Port a, b  input  WIDTH each  operands.
REQ-008 Port out_valid  output  1  result/flags valid.
REQ-009 Port out_ready  input  1  consumer takes result.
REQ-010 Port result  output  WIDTH  operation result.
REQ-011 Port flags  output  4  {V,N,Z,C}, registered status.

Function
REQ-012 Opcodes SHALL be: 0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 AND, 5 OR, 6 XOR, 7 NOT(a), 8 SHL, 9 SHR, 10 MUL; 11-15 illegal.
REQ-013 Request SHALL be accepted on an edge where in_valid && in_ready; op/a/b captured then.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 Ops 0-7 and illegal ops: IDLE->DONE; out_valid at accept cycle +1.
REQ-016 SHL/SHR: shift count = b[log2(WIDTH)-1:0]; one bit per cycle in BUSY; out_valid at accept +count+1; count 0 goes straight to DONE with result=a, C=0.
REQ-017 MUL: unsigned shift-add, one partial product per cycle, WIDTH BUSY cycles; result = low WIDTH bits; out_valid at accept +WIDTH+1.
REQ-018 DONE SHALL hold result and flags stable until out_ready=1; then ->IDLE next edge; no new accept in same cycle.
REQ-019 ADC = a+b+C, SBB = a-b-C, where C is the registered carry from the last completed op.
REQ-020 C: add carry-out; sub borrow (1 when a < b+cin); shifts last bit shifted out; MUL 1 if high half nonzero; logic/NOT/illegal 0.
REQ-021 V: signed overflow for ops 0-3; MUL V=C; all others 0.
REQ-022 Z = (result==0); N = result[WIDTH-1]; for all ops.
REQ-023 Illegal op: result 0, flags {0,0,1,0}.
REQ-024 flags SHALL update only on entering DONE; otherwise hold.
REQ-025 in_valid while not in_ready SHALL be ignored; operands changing during BUSY SHALL not affect the result.

Reset
REQ-026 On rst: state IDLE, in_ready=1, out_valid=0, result=0, flags=0, shift/mul counters 0.
REQ-027 rst in BUSY or DONE SHALL abandon the op; no out_valid for it; rst overrides in_valid.

Structure
REQ-028 Package alu_seq_pkg SHALL hold opcode constants, FSM state enum, flag bit indices.
REQ-029 Sub-module alu_seq_comb SHALL implement single-cycle ops 0-7 (result, C, V); iteration stays in alu_seq.

Verification (WIDTH=8)
REQ-030 ADD 0xFF+0x01 -> next cycle out_valid, result 0x00, flags C=1,Z=1,V=0,N=0.
REQ-031 Then ADC 0x10+0x20 -> result 0x31, C=0; then SUB 0x05-0x06 -> 0xFF, C=1,N=1; then SBB 0x10-0x00 -> 0x0F, C=0.
REQ-032 SHL a=0x81 b=3 -> in_ready 0 for BUSY, out_valid at accept+4, result 0x08, C=0; b=0 -> result 0x81 at accept+1.
REQ-033 MUL 0x10*0x10 -> out_valid at accept+9, result 0x00, C=1,V=1,Z=1; MUL 0x0F*0x03 -> 0x2D, C=0.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready 0, in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-035 rst asserted mid-MUL -> next edge in_ready=1, out_valid=0, flags 0; following ADC 1+1 -> 0x02.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state encoding and flag bit positions for alu_seq.
package alu_seq_pkg;

  // Operation codes; 11-15 are illegal.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  // Bit positions inside flags = {V,N,Z,C}.
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle datapath for opcodes 0-7: result, carry/borrow and signed overflow.
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH:0] wide;
  logic           cin_eff;

  // Arithmetic is done one bit wider so the top bit is carry-out (add) or borrow (sub).
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    res     = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    wide    = '0;
    cin_eff = ((op == OP_ADC) || (op == OP_SBB)) ? cin : 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        wide  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin_eff);
        res   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        // A negative difference leaves bit WIDTH set, i.e. a < b + cin.
        wide  = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin_eff);
        res   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops via alu_seq_comb, bit-serial shifts and a
// shift-add multiplier iterated in a BUSY state, result held in DONE until taken.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  state_e             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;       // shift register for SHL/SHR, multiplicand for MUL
  logic [2*WIDTH-1:0] prod_q;    // {partial sum, remaining multiplier bits}
  logic [CW-1:0]      cnt_q;     // iterations left in BUSY

  logic [WIDTH-1:0]   comb_res;
  logic               comb_c;
  logic               comb_v;

  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   sh_next;
  logic               sh_out;

  logic               fin;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_c;
  logic               fin_v;

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .op    (op),
    .a     (a),
    .b     (b),
    .cin   (flags[FLAG_C]),
    .res   (comb_res),
    .carry (comb_c),
    .ovf   (comb_v)
  );

  // One iteration step of the multiplier and shifter, and the values committed on entering DONE.
  always_comb begin
    shamt    = b[SW-1:0];
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    if (op_q == OP_SHR) begin
      sh_next = {1'b0, a_q[WIDTH-1:1]};
      sh_out  = a_q[0];
    end else begin
      sh_next = {a_q[WIDTH-2:0], 1'b0};
      sh_out  = a_q[WIDTH-1];
    end

    fin     = 1'b0;
    fin_res = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if ((op == OP_SHL) || (op == OP_SHR)) begin
            if (shamt == '0) begin
              fin     = 1'b1;
              fin_res = a;
            end
          end else if (op == OP_MUL) begin
            fin = 1'b0;
          end else if (op <= OP_NOT) begin
            fin     = 1'b1;
            fin_res = comb_res;
            fin_c   = comb_c;
            fin_v   = comb_v;
          end else begin
            fin = 1'b1;   // illegal op: zero result, only Z set
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == CW'(1)) begin
          fin = 1'b1;
          if (op_q == OP_MUL) begin
            fin_res = mul_next[WIDTH-1:0];
            fin_c   = |mul_next[2*WIDTH-1:WIDTH];
            fin_v   = fin_c;
          end else begin
            fin_res = sh_next;
            fin_c   = sh_out;
          end
        end
      end
      default: fin = 1'b0;
    endcase
  end

  // Control FSM with registered handshake outputs, result and flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q   <= op;
            a_q    <= a;
            prod_q <= {{WIDTH{1'b0}}, b};
            cnt_q  <= (op == OP_MUL) ? CW'(WIDTH) : CW'(shamt);
            if (!fin) begin
              state    <= S_BUSY;
              in_ready <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (op_q == OP_MUL) prod_q <= mul_next;
          else                a_q    <= sh_next;
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Entering DONE overrides the state-local updates above.
      if (fin) begin
        state     <= S_DONE;
        in_ready  <= 1'b0;
        out_valid <= 1'b1;
        result    <= fin_res;
        flags     <= {fin_v, fin_res[WIDTH-1], (fin_res == '0), fin_c};
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed steps plus random ops
// compared against an integer-arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int n_cmp = 0;
  int n_bad = 0;
  int model_c = 0;   // carry flag left by the last completed op

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= M/2) ? x - M : x;
  endfunction

  // Reference: result, {V,N,Z,C} and cycles from accept to out_valid.
  task automatic model(input int o, input int x, input int y, input int cin,
                       output int r, output logic [3:0] f, output int lat);
    int s, ss, n, c, v;
    longint p;
    c = 0; v = 0; lat = 1; r = 0;
    case (o)
      0, 1: begin
        s  = x + y + ((o == 1) ? cin : 0);
        ss = to_signed(x) + to_signed(y) + ((o == 1) ? cin : 0);
        r  = s % M;
        c  = (s >= M) ? 1 : 0;
        v  = (ss >= M/2 || ss < -M/2) ? 1 : 0;
      end
      2, 3: begin
        s  = x - y - ((o == 3) ? cin : 0);
        ss = to_signed(x) - to_signed(y) - ((o == 3) ? cin : 0);
        r  = (s + M) % M;
        c  = (s < 0) ? 1 : 0;
        v  = (ss >= M/2 || ss < -M/2) ? 1 : 0;
      end
      4: r = x & y;
      5: r = x | y;
      6: r = x ^ y;
      7: r = (M - 1) - x;
      8: begin
        n   = y % W;
        r   = (x << n) % M;
        c   = (n > 0) ? ((x >> (W - n)) & 1) : 0;
        lat = n + 1;
      end
      9: begin
        n   = y % W;
        r   = x >> n;
        c   = (n > 0) ? ((x >> (n - 1)) & 1) : 0;
        lat = n + 1;
      end
      10: begin
        p   = longint'(x) * longint'(y);
        r   = int'(p % M);
        c   = (p >= M) ? 1 : 0;
        v   = c;
        lat = W + 1;
      end
      default: r = 0;
    endcase
    f = {v[0], (r >= M/2), (r == 0), c[0]};
  endtask

  // Issue one request, verify latency/result/flags, hold DONE for 'hold' cycles, then drain.
  task automatic run_op(input int o, input int x, input int y, input int hold, input string tag);
    int er, elat, lat;
    logic [3:0] ef;
    bit seen;
    model(o, x, y, model_c, er, ef, elat);
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    op        = 4'(o);
    a         = W'(x);
    b         = W'(y);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
      else check({tag, "_busy_rdy"}, in_ready, 0);
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_result"}, result, er);
    check({tag, "_flags"}, flags, ef);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op = 4'($urandom); a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_rdy"}, in_ready, 0);
      check({tag, "_hold_result"}, result, er);
      check({tag, "_hold_flags"}, flags, ef);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_drain_valid"}, out_valid, 0);
    check({tag, "_drain_rdy"}, in_ready, 1);
    check({tag, "_drain_flags"}, flags, ef);
    out_ready = 1'b0;
    model_c = int'(ef[0]);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_flags", flags, 0);
    rst = 1'b0;
    model_c = 0;

    // Directed arithmetic chain exercising the registered carry.
    run_op(0, 8'hFF, 8'h01, 0, "add_ff_01");
    run_op(1, 8'h10, 8'h20, 0, "adc");
    run_op(2, 8'h05, 8'h06, 0, "sub");
    run_op(3, 8'h10, 8'h00, 0, "sbb");
    run_op(8, 8'h81, 8'h03, 0, "shl3");
    run_op(8, 8'h81, 8'h00, 0, "shl0");
    run_op(9, 8'h81, 8'h07, 0, "shr7");
    run_op(10, 8'h10, 8'h10, 0, "mul_10_10");
    run_op(10, 8'h0F, 8'h03, 0, "mul_0f_03");
    run_op(12, 8'h55, 8'hAA, 0, "illegal");
    run_op(7, 8'h5A, 8'h00, 5, "not_backpressure");

    // Reset in the middle of a multiply abandons it.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd10; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_flags", flags, 0);
    check("midrst_result", result, 0);
    model_c = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_valid", out_valid, 0);
    end
    run_op(1, 8'h01, 8'h01, 0, "adc_after_rst");

    // Random traffic across all opcodes.
    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, M - 1)),
             int'($urandom_range(0, M - 1)), int'($urandom_range(0, 2)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
